// File: rtl/node_integrator.sv
// Node model: sums the signed device currents on one node, integrates them into a
// clamped node voltage, and resolves it to a logic level with hysteresis and a settle flag.
module node_integrator #(
  parameter int W             = 16,
  parameter int N_IN          = 4,
  parameter int CAP_SHIFT     = 2,
  parameter int VHI           = 16383,
  parameter int VLO           = -16384,
  parameter int TH_HI         = 2048,
  parameter int TH_LO         = -2048,
  parameter int INIT_HI       = 0,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                eclk,
  input  logic                erst,
  input  logic                en,
  input  logic [N_IN*W-1:0]   i_in,
  output logic signed [W-1:0] v,
  output logic                p,
  output logic                rise,
  output logic                fall,
  output logic                settled
);

  // Sum width holds N_IN full-scale currents; one extra bit lets v + delta never wrap.
  localparam int SW = W + $clog2(N_IN) + 1;
  localparam int XW = SW + 1;

  localparam logic signed [XW-1:0] VHI_X    = XW'(VHI);
  localparam logic signed [XW-1:0] VLO_X    = XW'(VLO);
  localparam logic signed [W-1:0]  VHI_W    = W'(VHI);
  localparam logic signed [W-1:0]  VLO_W    = W'(VLO);
  localparam logic signed [W-1:0]  TH_HI_W  = W'(TH_HI);
  localparam logic signed [W-1:0]  TH_LO_W  = W'(TH_LO);
  localparam logic [7:0]           SETTLE_W = 8'(SETTLE_CYCLES);

  typedef enum logic {LOW = 1'b0, HIGH = 1'b1} level_t;

  localparam level_t                ST_RST = (INIT_HI != 0) ? HIGH : LOW;
  localparam logic signed [W-1:0]   V_RST  = (INIT_HI != 0) ? VHI_W : VLO_W;

  level_t               state, state_next;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] delta;
  logic signed [XW-1:0] v_wide;
  logic signed [W-1:0]  v_next;
  logic [7:0]           cnt, cnt_next;
  logic                 rise_next, fall_next;

  always_comb begin
    sum = '0;
    for (int k = 0; k < N_IN; k++) begin
      sum = sum + SW'($signed(i_in[k*W +: W]));
    end
  end

  assign delta  = sum >>> CAP_SHIFT;
  assign v_wide = XW'(v) + XW'(delta);

  always_comb begin
    if (v_wide > VHI_X)      v_next = VHI_W;
    else if (v_wide < VLO_X) v_next = VLO_W;
    else                     v_next = W'(v_wide);
  end

  // Level, edge pulses and settle counter all derive from v_next so they
  // stay consistent with the v registered on the same edge.
  always_comb begin
    state_next = state;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    cnt_next   = cnt;
    if (en) begin
      if (state == LOW && v_next >= TH_HI_W) begin
        state_next = HIGH;
        rise_next  = 1'b1;
      end else if (state == HIGH && v_next <= TH_LO_W) begin
        state_next = LOW;
        fall_next  = 1'b1;
      end
      if (v_next == v) cnt_next = (cnt == SETTLE_W) ? cnt : cnt + 8'd1;
      else             cnt_next = '0;
    end
  end

  always_ff @(posedge eclk or posedge erst) begin
    if (erst) begin
      state <= ST_RST;
      v     <= V_RST;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      rise  <= rise_next;
      fall  <= fall_next;
      if (en) v <= v_next;
    end
  end

  assign p       = (state == HIGH);
  assign settled = (cnt == SETTLE_W);

endmodule

// File: tb/tb_node_integrator.sv
// Bench for node_integrator: directed ramps plus random currents, checked every
// cycle against an arithmetic model of the node, with literal pins on key points.
module tb_node_integrator;

  localparam int W             = 16;
  localparam int N_IN          = 4;
  localparam int CAP_SHIFT     = 2;
  localparam int VHI           = 16383;
  localparam int VLO           = -16384;
  localparam int TH_HI         = 2048;
  localparam int TH_LO         = -2048;
  localparam int SETTLE_CYCLES = 8;

  logic                eclk;
  logic                erst;
  logic                en;
  logic [N_IN*W-1:0]   i_in;
  logic signed [W-1:0] v;
  logic                p, rise, fall, settled;

  int total = 0;
  int bad   = 0;

  node_integrator #(
    .W(W), .N_IN(N_IN), .CAP_SHIFT(CAP_SHIFT), .VHI(VHI), .VLO(VLO),
    .TH_HI(TH_HI), .TH_LO(TH_LO), .INIT_HI(0), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .eclk(eclk), .erst(erst), .en(en), .i_in(i_in),
    .v(v), .p(p), .rise(rise), .fall(fall), .settled(settled)
  );

  // ---------------- clock / reset ----------------
  initial eclk = 1'b0;
  always #5 eclk = ~eclk;

  // ---------------- reference model ----------------
  int m_v;
  bit m_p, m_rise, m_fall;
  int m_run;  // length of the current run of unchanged enabled cycles

  function automatic int floor_div(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  always @(posedge eclk or posedge erst) begin
    int s, nv;
    if (erst) begin
      m_v    <= VLO;
      m_p    <= 1'b0;
      m_rise <= 1'b0;
      m_fall <= 1'b0;
      m_run  <= 0;
    end else if (!en) begin
      m_rise <= 1'b0;
      m_fall <= 1'b0;
    end else begin
      s = 0;
      for (int k = 0; k < N_IN; k++) s += int'($signed(i_in[k*W +: W]));
      nv = m_v + floor_div(s, 1 << CAP_SHIFT);
      if (nv > VHI) nv = VHI;
      if (nv < VLO) nv = VLO;
      m_rise <= (!m_p && nv >= TH_HI);
      m_fall <= (m_p && nv <= TH_LO);
      if (!m_p && nv >= TH_HI) m_p <= 1'b1;
      else if (m_p && nv <= TH_LO) m_p <= 1'b0;
      m_run <= (nv == m_v) ? m_run + 1 : 0;
      m_v   <= nv;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge eclk) begin
    check("v", int'(v), m_v);
    check("p", int'(p), int'(m_p));
    check("rise", int'(rise), int'(m_rise));
    check("fall", int'(fall), int'(m_fall));
    check("settled", int'(settled), int'(m_run >= SETTLE_CYCLES));
    if (rise && fall) check("rise_fall_excl", 1, 0);
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input int a, input int b, input int c, input int d);
    i_in = {W'(d), W'(c), W'(b), W'(a)};
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge eclk);
  endtask

  task automatic rand_cycle();
    int mode;
    mode = $urandom_range(0, 3);
    en   = ($urandom_range(0, 9) != 0);
    case (mode)
      0: set_in($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
                $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768);
      1: set_in($urandom_range(0, 40) - 20, $urandom_range(0, 40) - 20,
                $urandom_range(0, 40) - 20, $urandom_range(0, 40) - 20);
      2: begin
        int x;
        x = $urandom_range(0, 2000) - 1000;
        set_in(x, -x, 0, 0);
      end
      default: set_in($urandom_range(0, 8192) - 4096, 0, 0, 0);
    endcase
    edges(1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    erst = 1'b1;
    en   = 1'b0;
    set_in(0, 0, 0, 0);
    edges(3);
    erst = 1'b0;
    check("rst_v", int'(v), -16384);
    check("rst_p", int'(p), 0);
    check("rst_settled", int'(settled), 0);

    // ramp up
    en = 1'b1;
    set_in(4096, 0, 0, 0);
    edges(1);
    check("ramp_e1", int'(v), -15360);
    edges(17);
    check("ramp_e18_v", int'(v), 2048);
    check("ramp_e18_p", int'(p), 1);
    check("ramp_e18_rise", int'(rise), 1);
    edges(1);
    check("ramp_e19_rise", int'(rise), 0);
    edges(13);
    check("ramp_e32_v", int'(v), 16383);
    edges(7);
    check("ramp_e39_settled", int'(settled), 0);
    edges(1);
    check("ramp_e40_settled", int'(settled), 1);

    // hysteresis on the way down
    set_in(-4096, 0, 0, 0);
    edges(17);
    check("hys_e17_v", int'(v), -1025);
    check("hys_e17_p", int'(p), 1);
    edges(1);
    check("hys_e18_v", int'(v), -2049);
    check("hys_e18_p", int'(p), 0);
    check("hys_e18_fall", int'(fall), 1);

    // floor rounding: sum -5 -> delta -2
    set_in(3, -8, 0, 0);
    edges(1);
    check("round_v", int'(v), -2051);

    // cancelling currents
    set_in(100, -100, 7, -7);
    edges(7);
    check("cancel_e7_settled", int'(settled), 0);
    edges(1);
    check("cancel_e8_settled", int'(settled), 1);
    check("cancel_v", int'(v), -2051);

    // enable freeze mid-ramp
    set_in(4096, 0, 0, 0);
    edges(3);
    check("freeze_pre_v", int'(v), 1021);
    en = 1'b0;
    edges(5);
    check("freeze_v", int'(v), 1021);
    check("freeze_p", int'(p), 0);
    check("freeze_rise", int'(rise), 0);
    en = 1'b1;
    edges(1);
    check("resume_v", int'(v), 2045);
    edges(1);
    check("resume_rise", int'(rise), 1);

    // random traffic
    for (int i = 0; i < 400; i++) rand_cycle();

    // async reset between edges while high and ramping
    en = 1'b1;
    set_in(4096, 4096, 0, 0);
    edges(20);
    check("pre_rst_p", int'(p), 1);
    set_in(-4096, 0, 0, 0);
    edges(2);
    #2;
    erst = 1'b1;
    #1;
    check("async_rst_v", int'(v), -16384);
    check("async_rst_p", int'(p), 0);
    check("async_rst_fall", int'(fall), 0);
    check("async_rst_rise", int'(rise), 0);
    edges(2);
    erst = 1'b0;
    for (int i = 0; i < 100; i++) rand_cycle();

    edges(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/node_integrator.md
# node_integrator

Digital node model that is the receiving end of the signed current bus driven by the transistor, pullup and pad models. Each `eclk` it sums all currents presented on one node and integrates them into a registered node voltage on the same signed `W`-bit scale as `HI`/`LO`. It resolves the voltage to a logic level with hysteresis and flags when the node has stopped moving. One instance sits per simulated node, between the transistor current outputs and the `v` inputs of every device attached to that node.

## Interface
- `W`, 16: voltage/current word width, signed two's complement.
- `N_IN`, 4: number of current inputs summed on the node (1..16).
- `CAP_SHIFT`, 2: node capacitance; the summed current is arithmetically shifted right by this amount before integration (0..8).
- `VHI`, 16383: upper clamp for `v`.
- `VLO`, -16384: lower clamp for `v`.
- `TH_HI`, 2048: rising threshold.
- `TH_LO`, -2048: falling threshold (must be < `TH_HI`).
- `INIT_HI`, 0: node reset level (1 = `VHI`, 0 = `VLO`).
- `SETTLE_CYCLES`, 8: consecutive unchanged cycles required for `settled` (1..255).

Ports:
- `eclk`  in  1  simulation clock.
- `erst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  integrate enable; 0 freezes all state.
- `i_in`  in  `N_IN*W`  packed signed currents; slice k is `i_in[k*W +: W]`.
- `v`  out  `W`  registered node voltage, signed.
- `p`  out  1  registered logic level of the node.
- `rise`  out  1  one-cycle pulse on a `p` 0->1 transition.
- `fall`  out  1  one-cycle pulse on a `p` 1->0 transition.
- `settled`  out  1  node voltage has been unchanged for `SETTLE_CYCLES` enabled cycles.

## Operation
- Sum: all `N_IN` slices are sign-extended to `W+clog2(N_IN)+1` bits and added. The sum is never truncated.
- Scale: `delta = sum >>> CAP_SHIFT`. This is an arithmetic shift, rounding toward minus infinity (-5>>>2 = -2).
- Integrate: `v_next = v + delta` in the wide width, then clamped to [`VLO`,`VHI`] before being registered.
- Level state machine, states LOW/HIGH:
  - LOW -> HIGH when `v_next >= TH_HI`.
  - HIGH -> LOW when `v_next <= TH_LO`.
  - Otherwise the state holds.
  - `p` = (state == HIGH).
- Settle counter, 8-bit, saturating at `SETTLE_CYCLES`:
  - When `v_next == v`, the counter increments.
  - Otherwise the counter clears to 0 and `settled` clears.
  - `settled` = (counter == `SETTLE_CYCLES`).
  - A clamped node with a nonzero `delta` counts as unchanged.
- `en`=0: `v`, the state, the counter and `settled` hold. `rise`/`fall` are 0.
- Opposing currents that sum to 0 produce `delta` 0. The node counts as unchanged.

## Timing
- Reset (async assert, applied immediately):
  - `v` = `INIT_HI ? VHI : VLO`.
  - `p` = `INIT_HI`.
  - `rise` = `fall` = 0, `settled` = 0, counter = 0.
- Deassertion is sampled at the next `eclk` rise. The first integration happens on the first edge with `erst` low.
- Latency: a current applied before edge n is reflected in `v` after edge n (1 cycle). `p`, `rise`/`fall` and `settled` are updated at the same edge from `v_next`, so they are always consistent with the `v` they accompany.
- `rise`/`fall` are high for exactly the one cycle following the transition edge. They are never both high at once.
- Reset mid-ramp discards all accumulated state. No pulse is generated on reset.

## Test plan
- Reset with `INIT_HI`=0, then release -> `v`=-16384, `p`=0, `settled`=0 before any edge.
- Ramp: `i_in[0]`=+4096, others 0, `en`=1:
  - `v` = -16384 + 1024k after edge k.
  - `p` and `rise` go high after edge 18 (`v`=2048). `rise` drops after edge 19.
  - `v` clamps to 16383 at edge 32.
  - `settled`=1 after edge 40.
- Hysteresis: from `p`=1, `v`=16383, drive -4096 (delta -1024):
  - `p` stays 1 through `v`=-1025 (edge 17).
  - `p` falls with a `fall` pulse at edge 18 (`v`=-2049).
- Rounding/cancel:
  - Inputs +3, -8, 0, 0 -> delta -2 per cycle.
  - Inputs +100, -100, +7, -7 -> `v` unchanged; `settled` asserts after 8 edges.
- Enable freeze: drop `en` mid-ramp for 5 cycles -> `v`, `p` and counter are frozen and `rise` stays 0. The ramp resumes on re-enable.
- Async reset asserted between edges mid-ramp -> `v` returns to -16384 immediately, with no `fall` pulse.
